// File: rtl/s_ahb2wb.sv
// AHB-Lite slave to Wishbone classic master bridge: one Wishbone cycle per AHB
// transfer, AHB data phase stretched with HREADYOUT until ack/err or watchdog.
module s_ahb2wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic [1:0]            HRESP,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic [2:0]            wb_cti_o,
  output logic [1:0]            wb_bte_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [TO_W-1:0]       wdog_q, wdog_d;

  logic       can_cap, capture, legal, timeout;
  logic [3:0] sel_dec;

  always_comb begin
    sel_dec = 4'b0000;
    legal   = 1'b0;
    case (HSIZE)
      3'd0: begin sel_dec = 4'b0001 << HADDR[1:0]; legal = 1'b1; end
      3'd1: begin sel_dec = HADDR[1] ? 4'b1100 : 4'b0011; legal = ~HADDR[0]; end
      3'd2: begin sel_dec = 4'b1111; legal = (HADDR[1:0] == 2'b00); end
      default: ;
    endcase
  end

  // A new address phase is only accepted once the previous data phase is finishing.
  assign can_cap = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign capture = HSEL & HREADY & HTRANS[1] & can_cap;
  assign timeout = (TIMEOUT != 0) && (wdog_q == TO_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_WB: begin
        wdog_d = wdog_q + 1'b1;
        if (wb_err_i) begin
          state_d = S_ERR1;
        end else if (wb_ack_i) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = wb_dat_i;
        end else if (timeout) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:         state_d = S_ERR2;
      S_DONE, S_ERR2: state_d = S_IDLE;
      default: ;
    endcase
    if (capture) begin
      wdog_d  = '0;
      state_d = legal ? S_WB : S_ERR1;
      if (legal) begin
        adr_d = HADDR;
        we_d  = HWRITE;
        sel_d = sel_dec;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      rdata_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      wdog_q  <= wdog_d;
    end
  end

  assign wb_cyc_o  = (state_q == S_WB);
  assign wb_stb_o  = (state_q == S_WB);
  assign wb_adr_o  = adr_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = HWDATA;
  assign wb_cti_o  = 3'b000;
  assign wb_bte_o  = 2'b00;
  assign HREADYOUT = ~((state_q == S_WB) || (state_q == S_ERR1));
  assign HRESP     = {1'b0, (state_q == S_ERR1) || (state_q == S_ERR2)};
  assign HRDATA    = rdata_q;

endmodule
